// File: rtl/regspill_pkg.sv
// regspill_pkg: shared state encoding and default widths for the register spill/fill engine.
package regspill_pkg;
    typedef enum logic [1:0] {IDLE, SPILL, FILL, DONE} state_t;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/regspill_ptr.sv
// regspill_ptr: wrapping register pointer with remaining-word count.
// The count is one bit wider than the pointer so that a full range of 2^ADDR_W registers fits.
module regspill_ptr
    import regspill_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W:0]   count,
    output logic              is_last
);
    logic [ADDR_W-1:0] span;
    assign span    = last_reg - first_reg;
    assign is_last = count == (ADDR_W+1)'(1);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (load) begin
            ptr   <= first_reg;
            count <= {1'b0, span} + (ADDR_W+1)'(1);
        end else if (step) begin
            ptr   <= ptr + ADDR_W'(1);
            count <= count - (ADDR_W+1)'(1);
        end
    end
endmodule

// File: rtl/regspill.sv
// regspill: streams a register range out (spill) or in (fill) through a register-file port.
// Optional running checksum of transferred words is enabled by defining REGSPILL_CHECKSUM_EN.
module regspill
    import regspill_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_spill,
    input  logic              start_fill,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rf_addr_read,
    input  logic [DATA_W-1:0] rf_data_read,
    output logic [ADDR_W-1:0] rf_addr_write,
    output logic              rf_en_write,
    output logic [DATA_W-1:0] rf_data_write,
    output logic              so_valid,
    input  logic              so_ready,
    output logic [DATA_W-1:0] so_data,
    output logic              so_last,
    input  logic              si_valid,
    output logic              si_ready,
    input  logic [DATA_W-1:0] si_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   count;
    logic              is_last;
    logic              load;
    logic              xfer;

    assign load          = (state == IDLE) && (start_spill || start_fill);
    assign so_valid      = state == SPILL;
    assign si_ready      = state == FILL;
    assign xfer          = (so_valid && so_ready) || (si_ready && si_valid);
    assign busy          = so_valid || si_ready;
    assign done          = state == DONE;
    assign rf_addr_read  = ptr;
    assign so_data       = rf_data_read;
    assign so_last       = so_valid && is_last;
    assign rf_addr_write = ptr;
    assign rf_en_write   = si_ready && si_valid;
    assign rf_data_write = si_data;

    regspill_ptr #(.ADDR_W(ADDR_W)) u_ptr (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .step      (xfer),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .ptr       (ptr),
        .count     (count),
        .is_last   (is_last)
    );

    // Spill has priority when both starts arrive together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            case (state)
                IDLE:        state <= start_spill ? SPILL : start_fill ? FILL : IDLE;
                SPILL, FILL: state <= (xfer && is_last) ? DONE : state;
                default:     state <= IDLE;
            endcase
    end

`ifdef REGSPILL_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            checksum <= '0;
        else if (load)
            checksum <= '0;
        else if (xfer)
            checksum <= checksum + (so_valid ? rf_data_read : si_data);
    end
`else
    assign checksum = '0;
`endif
endmodule

// File: doc/regspill.md
REGSPILL -- requirements
Module: regspill

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register data width.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width (32 registers).
REQ-003 SHALL have port clock  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port start_spill  in  1: one-cycle request to read a register range out to the stream.
REQ-006 SHALL have port start_fill  in  1: one-cycle request to write a register range from the stream.
REQ-007 SHALL have ports first_reg, last_reg  in  ADDR_W: inclusive range bounds, sampled at accepted start.
REQ-008 SHALL have ports rf_addr_read  out  ADDR_W and rf_data_read  in  DATA_W: register-file read port (combinational read).
REQ-009 SHALL have ports rf_addr_write  out  ADDR_W, rf_en_write  out  1, rf_data_write  out  DATA_W: register-file write port.
REQ-010 SHALL have ports so_valid  out  1, so_ready  in  1, so_data  out  DATA_W, so_last  out  1: spill stream out.
REQ-011 SHALL have ports si_valid  in  1, si_ready  out  1, si_data  in  DATA_W: fill stream in.
REQ-012 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), checksum  out  DATA_W.

Function
REQ-013 SHALL implement states IDLE, SPILL, FILL, DONE; busy=1 in SPILL and FILL only.
REQ-014 In IDLE, start_spill SHALL go to SPILL and start_fill to FILL; both asserted together: spill wins, fill dropped.
REQ-015 Start requests SHALL be ignored outside IDLE.
REQ-016 At accepted start, ptr SHALL load first_reg; remaining count SHALL load ((last_reg-first_reg) mod 2^ADDR_W)+1.
REQ-017 Range SHALL wrap 31->0 when last_reg<first_reg; first_reg==last_reg transfers exactly one register; 32 registers maximum.
REQ-018 In SPILL: rf_addr_read=ptr, so_data=rf_data_read, so_valid=1, so_last=1 when count==1.
REQ-019 so_data/so_addr SHALL stay stable while so_valid=1 and so_ready=0; transfer occurs only on so_valid&so_ready.
REQ-020 Each transfer SHALL advance ptr by 1 (mod 2^ADDR_W) and decrement count; transfer with count==1 goes to DONE.
REQ-021 In FILL: si_ready=1; on si_valid&si_ready, rf_en_write=1, rf_addr_write=ptr, rf_data_write=si_data, same cycle (combinational).
REQ-022 rf_en_write SHALL be 0 in every state except a FILL handshake cycle.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE; first start accepted the following cycle.
REQ-024 Zero-bubble throughput: one word per cycle when the partner handshake stays asserted.
REQ-025 While busy, external agents SHALL NOT write the register file (system rule, not checked).

Reset
REQ-026 reset_n low SHALL immediately force IDLE, ptr=0, count=0, checksum=0.
REQ-027 Under reset: so_valid=0, so_last=0, si_ready=0, rf_en_write=0, busy=0, done=0.
REQ-028 Reset mid-transfer SHALL abort with no further register writes; no done pulse.

Configuration
REQ-029 Macro REGSPILL_CHECKSUM_EN defined: checksum clears at accepted start, adds each transferred word (mod 2^DATA_W), holds after DONE until next start.
REQ-030 Macro REGSPILL_CHECKSUM_EN undefined: checksum tied to 0, no accumulator logic.

Structure
REQ-031 Package regspill_pkg SHALL hold state enum (IDLE,SPILL,FILL,DONE), DATA_W and ADDR_W defaults.
REQ-032 Sub-module regspill_ptr SHALL hold wrapping pointer plus remaining count (load, step, last flag).

Verification
REQ-033 Spill first=2,last=4, regs 2..4 = 0xA,0xB,0xC, so_ready=1 -> so_data 0xA,0xB,0xC on 3 consecutive cycles, so_last on 0xC, done next cycle.
REQ-034 Fill first=30,last=1, si_data 1,2,3,4 -> regs 30,31,0,1 written 1,2,3,4; checksum=10 with macro, 0 without.
REQ-035 Spill first=last=7, so_ready low 5 cycles -> so_valid held, so_data constant, exactly one transfer, done once.
REQ-036 start_spill and start_fill same cycle -> SPILL entered, rf_en_write never asserts.
REQ-037 reset_n low after 2 of 4 fill words -> busy=0 at once, later si_valid writes nothing, no done.
REQ-038 start_fill asserted during SPILL -> ignored; spill completes normally.
